seq_subtractor: RTL

- Multi-cycle 64-bit subtractor for the Y86-64 execute stage.
- Computes diff = b - a as b + ~a + 1, processing CHUNK bits per cycle from the LSB with a registered borrow chain.
- Produces Y86 condition flags ZF, SF and OF, plus a borrow flag CF, for subq/cmp.
- Start/done handshake lets the pipeline stall on it while other units proceed.

---
 rtl/seq_subtractor_pkg.sv | 27 ++
 rtl/seq_subtractor_if.sv | 27 ++
 rtl/seq_subtractor_sub_chunk.sv | 17 +
 rtl/seq_subtractor.sv | 125 ++++++++++++
 4 files changed

// File: rtl/seq_subtractor_pkg.sv
// seq_sub_pkg: shared types and sizing helpers for the multi-cycle subtractor.
//   state_t      : FSM states IDLE / RUN / DONE
//   DEF_WIDTH    : default operand width (64)
//   DEF_CHUNK    : default bits processed per cycle (16)
//   num_chunks() : cycles per operation, WIDTH/CHUNK
//   idx_w()      : chunk index width, never below 1 bit
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  function automatic int num_chunks(input int w, input int c);
    return w / c;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_subtractor_if.sv
// seq_subtractor_if: start/done handshake plus operands and results.
//   master : issues start/a/b, observes busy/done/diff/flags (execute stage)
//   slave  : the subtractor itself
interface seq_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             zf;
  logic             sf;
  logic             of;
  logic             cf;

  modport master (
    output start, a, b,
    input  busy, done, diff, zf, sf, of, cf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, zf, sf, of, cf
  );
endinterface

// File: rtl/seq_subtractor_sub_chunk.sv
// sub_chunk: combinational W-bit slice computing x + ~y + cin.
//   x    : minuend slice
//   y    : subtrahend slice (inverted inside)
//   cin  : carry in (1 for the lowest slice, the "+1" of two's complement)
//   sum  : slice result
//   cout : carry out; its inverse on the top slice is the borrow
module sub_chunk #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, cin};
endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle diff = b - a for the Y86-64 execute stage.
// One CHUNK-bit slice per cycle from the LSB, carry held in a register,
// so an operation takes N = WIDTH/CHUNK cycles in RUN plus one DONE cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_subtractor_if.slave (start, a, b -> busy, done, diff,
//              zf, sf, of, cf)
// Build option SEQ_SUB_ZERO_FASTPATH_EN: when a == 0 at an accepted start,
// skip RUN and present diff = b in the very next cycle.
// WIDTH must be an integer multiple of CHUNK.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic               clk,
  input  logic               rst,
  seq_subtractor_if.slave    bus
);
  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_w(N);

  state_t state, state_nx;

  // Operands and result viewed as N chunks so the active slice is a plain index.
  logic [N-1:0][CHUNK-1:0] a_lat, b_lat, diff_q;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    zacc;
  logic                    zf_q, sf_q, of_q, cf_q;

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             last;
  logic             fast;

  sub_chunk #(.W(CHUNK)) u_chunk (
    .x    (b_lat[idx]),
    .y    (a_lat[idx]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  assign last = (idx == IW'(N - 1));

`ifdef SEQ_SUB_ZERO_FASTPATH_EN
  assign fast = (bus.a == '0);
`else
  assign fast = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = fast ? DONE : RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lat  <= '0;
      b_lat  <= '0;
      diff_q <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      zf_q   <= 1'b0;
      sf_q   <= 1'b0;
      of_q   <= 1'b0;
      cf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_lat <= bus.a;
          b_lat <= bus.b;
          idx   <= '0;
          carry <= 1'b1;   // +1 of the two's-complement negate
          zacc  <= 1'b1;
          // b - 0 needs no arithmetic: copy b and derive flags directly.
          if (fast) begin
            diff_q <= bus.b;
            zf_q   <= (bus.b == '0);
            sf_q   <= bus.b[WIDTH-1];
            of_q   <= 1'b0;
            cf_q   <= 1'b0;
          end
        end
        RUN: begin
          diff_q[idx] <= sum;
          carry       <= cout;
          zacc        <= zacc & (sum == '0);
          idx         <= last ? '0 : idx + 1'b1;
          // Flags come from the top slice as it is produced, so they land
          // together with the last diff chunk.
          if (last) begin
            zf_q <= zacc & (sum == '0);
            sf_q <= sum[CHUNK-1];
            cf_q <= ~cout;
            of_q <= (a_lat[N-1][CHUNK-1] != b_lat[N-1][CHUNK-1]) &&
                    (sum[CHUNK-1] != b_lat[N-1][CHUNK-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.zf   = zf_q;
  assign bus.sf   = sf_q;
  assign bus.of   = of_q;
  assign bus.cf   = cf_q;

endmodule
